// File: rtl/div_clk_monitor_pkg.sv
// div_clk_monitor_pkg: types and constants shared by the divided-clock monitor.
//   state_e     - monitor state (idle / acquiring / locked)
//   timeout_cnt - counter value at which a missing edge is declared a timeout
package div_clk_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StLocked
  } state_e;

  // Width of the consecutive-match counter; lock thresholds are limited to 1..15.
  localparam int unsigned MatchW = 4;

  // Largest value representable in cnt_w bits (2^cnt_w - 1).
  function automatic int unsigned timeout_cnt(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/div_clk_monitor_sync_edge_det.sv
// div_clk_monitor_sync_edge_det: synchronizes an asynchronous clock-like signal
// into clk_in and flags its rising edges.
//   clk_in   - sampling clock
//   rst      - asynchronous active-high reset, clears the whole chain
//   async_in - asynchronous input
//   sync     - synchronized level (last stage of the chain)
//   rise     - one-cycle pulse: sync is 1 and was 0 on the previous cycle
module div_clk_monitor_sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_in};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period and high time of a divided clock in clk_in
// cycles, declares lock after LOCK_CNT repeats of the first measurement, and
// flags lock loss or a stopped clock.
//   clk_in     - measurement clock
//   rst        - asynchronous active-high reset
//   div_clk    - divided clock under test (asynchronous)
//   period     - last measured period
//   high_time  - cycles div_clk was high during the last measured period
//   meas_valid - one-cycle pulse when period/high_time update
//   locked     - high while measurements are stable
//   err        - one-cycle pulse on lock loss, timeout or duty fault
// Build option: define DIV_DUTY_CHECK_EN to require 50% duty for lock.
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  // Timeout fires on the cycle cnt would step onto the all-ones value, so an
  // edge at a full 2^CNT_W-1 period is still measured (edge takes priority).
  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(timeout_cnt(CNT_W) - 32'd1);
  localparam logic [MatchW-1:0] LockN   = MatchW'(LOCK_CNT);

  logic              sync, rise;
  logic              meas, timeout, duty_ok;
  logic [CNT_W-1:0]  new_period;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  period_q, period_d, high_q, high_d, prev_q, prev_d;
  logic [MatchW-1:0] match_q, match_d;
  logic              have_prev_q, have_prev_d;
  logic              mv_q, mv_d, err_q, err_d;

  div_clk_monitor_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .async_in(div_clk),
    .sync    (sync),
    .rise    (rise)
  );

  assign new_period = cnt_q + 1'b1;
  assign meas       = rise && (state_q != StIdle);
  assign timeout    = !rise && (cnt_q == CntLast);

`ifdef DIV_DUTY_CHECK_EN
  assign duty_ok = ({hcnt_q, 1'b0} == {1'b0, new_period});
`else
  assign duty_ok = 1'b1;
`endif

  always_comb begin
    cnt_d = (rise || timeout) ? '0 : cnt_q + 1'b1;
    // hcnt saturates so a stuck-high input cannot wrap it.
    if (rise)                      hcnt_d = CNT_W'(1);
    else if (sync && ~&hcnt_q)     hcnt_d = hcnt_q + 1'b1;
    else                           hcnt_d = hcnt_q;
  end

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    period_d    = period_q;
    high_d      = high_q;
    mv_d        = meas;
    err_d       = 1'b0;

    if (meas) begin
      period_d = new_period;
      high_d   = hcnt_q;
    end

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d     = StAcquire;
          match_d     = '0;
          have_prev_d = 1'b0;
        end
      end
      StAcquire: begin
        if (meas) begin
          if (have_prev_q && new_period == prev_q && duty_ok) begin
            match_d = match_q + 1'b1;
            if (match_d == LockN) state_d = StLocked;
          end else begin
            match_d     = '0;
            prev_d      = new_period;
            have_prev_d = 1'b1;
          end
        end
      end
      StLocked: begin
        if (meas && (new_period != prev_q || !duty_ok)) begin
          err_d   = 1'b1;
          state_d = StAcquire;
          match_d = '0;
          prev_d  = new_period;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d     = StIdle;
      match_d     = '0;
      have_prev_d = 1'b0;
      err_d       = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      prev_q      <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      mv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
      mv_q        <= mv_d;
      err_q       <= err_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = (state_q == StLocked);
  assign err        = err_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: self-checking bench for div_clk_monitor (default
// parameters). Expected values track DIV_DUTY_CHECK_EN when it is defined.
module tb_div_clk_monitor;

  localparam int unsigned CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             div_clk = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, locked, err;

  int n_checks = 0;
  int n_errors = 0;

  div_clk_monitor #(
    .CNT_W      (CNT_W),
    .LOCK_CNT   (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_clk   (div_clk),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;

  // Divided-clock generator: new ratio is picked up only at a period boundary.
  int unsigned gen_p = 4, gen_h = 2, cur_p = 4, cur_h = 0, gen_phase = 0;
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (gen_phase == 0) begin
        cur_p = gen_p;
        cur_h = gen_h;
      end
      div_clk   = (gen_phase < cur_h);
      gen_phase = (gen_phase + 1 >= cur_p) ? 0 : gen_phase + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait until the generator has just driven phase 2 of a 4-cycle period (low).
  task automatic wait_low_phase();
    int guard = 0;
    do begin
      @(posedge clk_in);
      #2;
      guard++;
    end while (gen_phase != 3 && guard < 100);
    check("phase_align", (gen_phase == 3) ? 1 : 0, 1);
  endtask

  // Observe n measurements starting with the first one whose period is ep.
  // err pulses are counted from the moment the task is entered.
  task automatic run_window(input string nm, input int unsigned ep, input int unsigned eh,
                            input int n, input int exp_err, input int exp_lock);
    int k = 0, bad_p = 0, bad_h = 0, errs = 0, lock_at = 0, budget = 0;
    bit started = 1'b0;
    while (k < n && budget < 4000) begin
      @(negedge clk_in);
      budget++;
      if (err) errs++;
      if (!started && meas_valid && period == CNT_W'(ep)) started = 1'b1;
      if (started && meas_valid) begin
        k++;
        if (period != CNT_W'(ep)) bad_p++;
        if (high_time != CNT_W'(eh)) bad_h++;
        if (locked && lock_at == 0) lock_at = k;
      end
    end
    check($sformatf("%s_meas_count", nm), k, n);
    check($sformatf("%s_period_bad", nm), bad_p, 0);
    check($sformatf("%s_high_bad", nm), bad_h, 0);
    check($sformatf("%s_err_pulses", nm), errs, exp_err);
    check($sformatf("%s_lock_at", nm), lock_at, exp_lock);
    check($sformatf("%s_locked_end", nm), int'(locked), (exp_lock != 0) ? 1 : 0);
  endtask

  typedef struct {
    string       name;
    int unsigned p;
    int unsigned h;
    int          n;
    int          exp_err;
    int          exp_lock;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, last_mv, errs;
    bit got;

`ifdef DIV_DUTY_CHECK_EN
    vecs[0] = '{"div4",   4,   2,   6, 0, 5};
    vecs[1] = '{"div8",   8,   4,   6, 1, 5};
    vecs[2] = '{"div2",   2,   1,   6, 1, 5};
    vecs[3] = '{"duty25", 8,   2,   6, 1, 0};
    vecs[4] = '{"div6",   6,   3,   6, 0, 5};
    vecs[5] = '{"p255",   255, 127, 3, 1, 0};
`else
    vecs[0] = '{"div4",   4,   2,   6, 0, 5};
    vecs[1] = '{"div8",   8,   4,   6, 1, 5};
    vecs[2] = '{"div2",   2,   1,   6, 1, 5};
    vecs[3] = '{"duty25", 8,   2,   6, 1, 5};
    vecs[4] = '{"div6",   6,   3,   6, 1, 5};
    vecs[5] = '{"p255",   255, 127, 3, 1, 0};
`endif

    // Reset state.
    #3;
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    wait_low_phase();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      gen_p = vecs[i].p;
      gen_h = vecs[i].h;
      run_window(vecs[i].name, vecs[i].p, vecs[i].h, vecs[i].n, vecs[i].exp_err,
                 vecs[i].exp_lock);
    end

    // Stuck-low input after lock at period 6: timeout 255 cycles after restart.
    gen_h   = 0;
    cyc     = 0;
    last_mv = 0;
    got     = 1'b0;
    while (!got && cyc < 1500) begin
      @(negedge clk_in);
      cyc++;
      if (meas_valid) last_mv = cyc;
      if (err) got = 1'b1;
    end
    check("stuck_err_seen", int'(got), 1);
    check("stuck_err_gap", cyc - last_mv, 255);
    check("stuck_locked", int'(locked), 0);
    check("stuck_period_hold", int'(period), 6);
    check("stuck_high_hold", int'(high_time), 3);

    // Restart at div-by-2: from idle the first edge only starts counting.
    gen_p = 2;
    gen_h = 1;
    cyc   = 0;
    errs  = 0;
    got   = 1'b0;
    while (!got && cyc < 600) begin
      @(negedge clk_in);
      cyc++;
      if (err && !meas_valid) errs++;
      if (meas_valid) got = 1'b1;
    end
    check("restart_meas_seen", int'(got), 1);
    check("restart_period", int'(period), 2);
    check("restart_high_time", int'(high_time), 1);
    check("restart_err", errs, 0);

    gen_p = 4;
    gen_h = 2;
    run_window("relock4", 4, 2, 6, 0, 5);

    // One-cycle reset during a low phase while locked.
    wait_low_phase();
    rst = 1'b1;
    #1;
    check("midrst_period", int'(period), 0);
    check("midrst_high_time", int'(high_time), 0);
    check("midrst_meas_valid", int'(meas_valid), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_err", int'(err), 0);
    @(posedge clk_in);
    #2;
    rst = 1'b0;
    run_window("post_rst", 4, 2, 5, 0, 5);

    // Full-scale period: edge coincides with the timeout point and wins.
    gen_p = vecs[5].p;
    gen_h = vecs[5].h;
    run_window(vecs[5].name, vecs[5].p, vecs[5].h, vecs[5].n, vecs[5].exp_err,
               vecs[5].exp_lock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
Receive-side companion to the even clock divider. Samples a divided clock (div_clk) in the clk_in domain and measures its period and high time in clk_in cycles. Declares lock after a run of identical periods and flags loss of lock or a stopped clock. Used to check divider outputs in-system and to report the active divide ratio to control logic.

Parameters:
CNT_W, 8, width of the period and high-time counters and outputs; maximum measurable period is 2^CNT_W-1.
LOCK_CNT, 4, number of consecutive repeat measurements needed to assert locked (range 1..15).
SYNC_STAGES, 2, number of synchronizer flops on div_clk (minimum 2).

Ports:
clk_in  input  1  measurement clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
div_clk  input  1  divided clock under test; treated as asynchronous.
period  output  CNT_W  last measured period in clk_in cycles.
high_time  output  CNT_W  clk_in cycles div_clk was high in the last measured period.
meas_valid  output  1  one-cycle pulse when period/high_time update.
locked  output  1  high while measurements are stable.
err  output  1  one-cycle pulse on lock loss, timeout, or duty fault.

Behaviour:
- Reset values: period=0, high_time=0, meas_valid=0, locked=0, err=0. State IDLE, counters 0, match count 0, sync chain 0.
- Reset is asynchronous active-high and may assert mid-measurement. All state returns to reset values immediately, with no pulse emitted.
- Sync: div_clk passes through SYNC_STAGES flops. Rising edge is detected as sync=1 and the previous sync=0 (one extra flop). Edge detection lags div_clk by SYNC_STAGES+1 clk_in cycles. The lag is constant, so period values are exact.
- Counters:
  - cnt increments every cycle. On a detected edge, cnt<=0.
  - hcnt increments while sync=1 and holds while sync=0. On an edge cycle, hcnt<=1.
- Measurement on edge, when state is not IDLE:
  - period<=cnt+1 and high_time<=hcnt.
  - meas_valid=1 in the following cycle, aligned with the new outputs.
  - Examples: div-by-2 gives 2/1; div-by-4 gives 4/2; div-by-8 gives 8/4.
- States:
  - IDLE: waits for the first edge, which only starts the counters. Edge -> ACQUIRE, match count 0, no meas_valid.
  - ACQUIRE: on the first measurement, store prev=period. On each later measurement:
    - if equal to prev, increment match;
    - otherwise set match=0 and prev=new.
    - When match reaches LOCK_CNT -> LOCKED. locked rises together with that meas_valid, i.e. on the (LOCK_CNT+1)-th identical measurement.
  - LOCKED: a measurement with period != prev causes an err pulse, locked=0, -> ACQUIRE, match=0, prev=new value.
- Timeout: cnt reaches 2^CNT_W-1 with no edge (stuck or too slow) from any state. Result: err pulse, locked=0, -> IDLE, cnt<=0, period/high_time hold their last values. cnt never wraps.
- Simultaneous edge and timeout: the edge wins (measurement taken, no timeout).
- err and meas_valid may pulse in the same cycle.

Optional Feature:
DIV_DUTY_CHECK_EN.
- Defined: in LOCKED, a measurement with high_time*2 != period is a duty fault. It causes an err pulse, locked=0, -> ACQUIRE. In ACQUIRE, a measurement failing the check resets match to 0, so lock is only reached with 50% duty (even ratios).
- Undefined: duty is not checked; high_time is still reported.

Decomposition:
Shared package: state enum (IDLE, ACQUIRE, LOCKED) and the timeout constant (2^CNT_W-1) expressed from CNT_W. One natural sub-module, sync_edge_det: synchronizer chain plus rising-edge detector, parameterized by SYNC_STAGES. The FSM and counters stay in div_clk_monitor.

Test Plan:
- Div-by-4 driven from an even counter on clk_in, rst released at t0 -> outputs period=4, high_time=2 on every meas_valid. locked=1 at the 5th meas_valid with LOCK_CNT=4; err never pulses.
- Ratio switch div-by-4 to div-by-8 while locked -> one err pulse and locked=0 on the first period=8 measurement. Relock at the 5th consecutive period=8.
- div_clk held at 0 after lock with CNT_W=8 -> err pulse 255 cycles after the last counter restart; locked=0, state IDLE, period still 4. Restarting div-by-2 gives the first meas_valid on the 2nd detected edge, with period=2.
- 25% duty period-8 input (high 2 cycles): with DIV_DUTY_CHECK_EN, locked never asserts and high_time=2. Without the macro, locked asserts at the 5th measurement.
- rst pulsed high for 1 cycle mid-period while locked -> all outputs 0 immediately and no err pulse. Lock reacquired after 1 start edge plus 5 measurements.
- Edge arriving in the same cycle cnt hits 255 (period 256 is not possible; use period 255 input) -> measurement taken with period=255, no err.
